ifu_ctrl: RTL and testbench

IFU_CTRL -- requirements
Module: ifu_ctrl

---
 rtl/ifu_ctrl_if.sv | 30 +++
 rtl/ifu_ctrl.sv | 111 +++++++++++
 tb/tb_ifu_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ifu_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ifu_ctrl_if                                                    |
// | Brief    : Control/redirect inputs and fetch outputs of the IFU PC unit. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface ifu_ctrl_if;
   logic        stall;
   logic [1:0]  npc_op;
   logic        br_taken;
   logic [15:0] imm16;
   logic [25:0] instr_index;
   logic [31:0] ra;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_valid;
   logic        fault;
   logic [31:0] fetch_cnt;

   modport master (
      output stall, npc_op, br_taken, imm16, instr_index, ra,
      input  pc, pc_plus4, fetch_valid, fault, fetch_cnt
   );

   modport slave (
      input  stall, npc_op, br_taken, imm16, instr_index, ra,
      output pc, pc_plus4, fetch_valid, fault, fetch_cnt
   );
endinterface
`default_nettype wire

// File: rtl/ifu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ifu_ctrl                                                       |
// | Brief    : PC sequencer with RUN/STALL/HALT control and fetch counter.   |
// |            Define IFU_ADDR_CHECK_EN to add fetch-address fault checking. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module ifu_ctrl #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000,
   parameter int          IM_WORDS = 4096
) (
   input  wire logic  clk,
   input  wire logic  reset,
   ifu_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   localparam logic [31:0] c_pc_last = PC_RESET + 32'(4 * IM_WORDS) - 32'd4;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_fetch_cnt;
   logic        r_fetch_valid;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_br_off;
   logic [31:0] w_next_pc;

   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_br_off   = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};

   always_comb begin
      w_next_pc = w_pc_plus4;
      case (bus.npc_op)
         2'b01:   w_next_pc = bus.br_taken ? (w_pc_plus4 + w_br_off) : w_pc_plus4;
         2'b10:   w_next_pc = {r_pc[31:28], bus.instr_index, 2'b00};
         2'b11:   w_next_pc = bus.ra;
         default: w_next_pc = w_pc_plus4;
      endcase
   end

`ifdef IFU_ADDR_CHECK_EN
   logic r_fault;
   logic w_legal;

   assign w_legal = (w_next_pc[1:0] == 2'b00) &&
                    (w_next_pc >= PC_RESET) && (w_next_pc <= c_pc_last);
   assign bus.fault = r_fault;
`else
   logic w_unused_cfg;

   // Range bound only matters when checking is compiled in.
   assign w_unused_cfg = ^c_pc_last;
   assign bus.fault    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_RUN;
         r_pc          <= PC_RESET;
         r_fetch_cnt   <= 32'd0;
         r_fetch_valid <= 1'b1;
`ifdef IFU_ADDR_CHECK_EN
         r_fault       <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_RUN: begin
               if (bus.stall) begin
                  r_state       <= ST_STALL;
                  r_fetch_valid <= 1'b0;
               end
`ifdef IFU_ADDR_CHECK_EN
               else if (!w_legal) begin
                  r_state       <= ST_HALT;
                  r_fetch_valid <= 1'b0;
                  r_fault       <= 1'b1;
               end
`endif
               else begin
                  r_pc        <= w_next_pc;
                  r_fetch_cnt <= r_fetch_cnt + 32'd1;
               end
            end
            // Leaving STALL spends one edge without a PC update so the
            // redirect inputs are re-sampled fresh in RUN.
            ST_STALL: begin
               if (!bus.stall) begin
                  r_state       <= ST_RUN;
                  r_fetch_valid <= 1'b1;
               end
            end
            default: begin
               r_state       <= ST_HALT;
               r_fetch_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pc          = r_pc;
   assign bus.pc_plus4    = w_pc_plus4;
   assign bus.fetch_valid = r_fetch_valid;
   assign bus.fetch_cnt   = r_fetch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ifu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ifu_ctrl                                                    |
// | Brief    : Directed vector bench for ifu_ctrl.                           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_ifu_ctrl;

   typedef struct {
      logic        rst;
      logic        stall;
      logic [1:0]  op;
      logic        br;
      logic [15:0] imm;
      logic [25:0] idx;
      logic [31:0] ra;
      logic [31:0] e_pc;
      logic        e_fv;
      logic [31:0] e_cnt;
      logic        e_fault;
   } vec_t;

   localparam int c_nvec = 23;

   logic clk;
   logic reset;
   int   tests;
   int   fails;
   vec_t tbl [c_nvec];

   ifu_ctrl_if bus ();

   ifu_ctrl #(
      .PC_RESET (32'h0000_3000),
      .IM_WORDS (4096)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic s, input logic [1:0] op,
                               input logic br, input logic [15:0] imm,
                               input logic [25:0] idx, input logic [31:0] ra,
                               input logic [31:0] pc, input logic fv,
                               input logic [31:0] cnt, input logic f);
      vec_t v;
      v.rst = r;  v.stall = s;  v.op = op;  v.br = br;  v.imm = imm;
      v.idx = idx; v.ra = ra;   v.e_pc = pc; v.e_fv = fv;
      v.e_cnt = cnt; v.e_fault = f;
      return v;
   endfunction

   task automatic check(input string nm, input vec_t v);
      logic [31:0] e_pc4;
      e_pc4 = v.e_pc + 32'd4;
      tests++;
      if (bus.pc !== v.e_pc || bus.pc_plus4 !== e_pc4 || bus.fetch_valid !== v.e_fv ||
          bus.fetch_cnt !== v.e_cnt || bus.fault !== v.e_fault) begin
         fails++;
         $display("FAIL %s: got pc=%h pc4=%h fv=%b cnt=%0d fault=%b, expected pc=%h pc4=%h fv=%b cnt=%0d fault=%b",
                  nm, bus.pc, bus.pc_plus4, bus.fetch_valid, bus.fetch_cnt, bus.fault,
                  v.e_pc, e_pc4, v.e_fv, v.e_cnt, v.e_fault);
      end
   endtask

   task automatic apply(input string nm, input vec_t v);
      reset           = v.rst;
      bus.stall       = v.stall;
      bus.npc_op      = v.op;
      bus.br_taken    = v.br;
      bus.imm16       = v.imm;
      bus.instr_index = v.idx;
      bus.ra          = v.ra;
      @(posedge clk);
      #1;
      check(nm, v);
   endtask

   initial begin
      tests = 0;
      fails = 0;

      //            rst stall op    br  imm       idx          ra              pc            fv  cnt    f
      tbl[0]  = mk(0, 0, 2'b00, 0, 16'h0000, 26'h0000000, 32'h0,          32'h0000_3004, 1, 32'd1,  0);
      tbl[1]  = mk(0, 0, 2'b00, 0, 16'h0000, 26'h0000000, 32'h0,          32'h0000_3008, 1, 32'd2,  0);
      tbl[2]  = mk(0, 0, 2'b00, 0, 16'h0000, 26'h0000000, 32'h0,          32'h0000_300C, 1, 32'd3,  0);
      tbl[3]  = mk(0, 0, 2'b01, 1, 16'hFFFE, 26'h0000000, 32'h0,          32'h0000_3008, 1, 32'd4,  0);
      tbl[4]  = mk(0, 0, 2'b01, 1, 16'hFFFE, 26'h0000000, 32'h0,          32'h0000_3004, 1, 32'd5,  0);
      tbl[5]  = mk(0, 0, 2'b00, 0, 16'h0000, 26'h0000000, 32'h0,          32'h0000_3008, 1, 32'd6,  0);
      tbl[6]  = mk(0, 0, 2'b01, 0, 16'hFFFE, 26'h0000000, 32'h0,          32'h0000_300C, 1, 32'd7,  0);
      tbl[7]  = mk(0, 0, 2'b11, 0, 16'h0000, 26'h0000000, 32'h0000_3000, 32'h0000_3000, 1, 32'd8,  0);
      tbl[8]  = mk(0, 0, 2'b10, 0, 16'h0000, 26'h0000C10, 32'h0,          32'h0000_3040, 1, 32'd9,  0);
      tbl[9]  = mk(0, 0, 2'b11, 0, 16'h0000, 26'h0000000, 32'h0000_3100, 32'h0000_3100, 1, 32'd10, 0);
      tbl[10] = mk(0, 0, 2'b11, 0, 16'h0000, 26'h0000000, 32'h0000_3010, 32'h0000_3010, 1, 32'd11, 0);
      tbl[11] = mk(0, 1, 2'b10, 0, 16'h0000, 26'h0000C10, 32'h0,          32'h0000_3010, 0, 32'd11, 0);
      tbl[12] = mk(0, 1, 2'b10, 0, 16'h0000, 26'h0000C10, 32'h0,          32'h0000_3010, 0, 32'd11, 0);
      tbl[13] = mk(0, 0, 2'b10, 0, 16'h0000, 26'h0000C10, 32'h0,          32'h0000_3010, 1, 32'd11, 0);
      tbl[14] = mk(0, 0, 2'b00, 0, 16'h0000, 26'h0000000, 32'h0,          32'h0000_3014, 1, 32'd12, 0);
      tbl[15] = mk(0, 0, 2'b01, 1, 16'h0004, 26'h0000000, 32'h0,          32'h0000_3028, 1, 32'd13, 0);
      tbl[16] = mk(0, 1, 2'b00, 0, 16'h0000, 26'h0000000, 32'h0,          32'h0000_3028, 0, 32'd13, 0);
      tbl[17] = mk(1, 1, 2'b11, 0, 16'h0000, 26'h0000000, 32'h0000_3100, 32'h0000_3000, 1, 32'd0,  0);
      tbl[18] = mk(0, 0, 2'b00, 0, 16'h0000, 26'h0000000, 32'h0,          32'h0000_3004, 1, 32'd1,  0);
      tbl[19] = mk(1, 0, 2'b11, 0, 16'h0000, 26'h0000000, 32'h0000_3100, 32'h0000_3000, 1, 32'd0,  0);
      tbl[20] = mk(0, 0, 2'b11, 0, 16'h0000, 26'h0000000, 32'h0000_5000, 32'h0000_5000, 1, 32'd1,  0);
      tbl[21] = mk(0, 0, 2'b10, 0, 16'h0000, 26'h0001000, 32'h0,          32'h0000_4000, 1, 32'd2,  0);
      tbl[22] = mk(0, 0, 2'b00, 1, 16'hFFFE, 26'h0000000, 32'h0,          32'h0000_4004, 1, 32'd3,  0);

      reset           = 1'b1;
      bus.stall       = 1'b0;
      bus.npc_op      = 2'b00;
      bus.br_taken    = 1'b0;
      bus.imm16       = 16'h0;
      bus.instr_index = 26'h0;
      bus.ra          = 32'h0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset", mk(1, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h0000_3000, 1, 32'd0, 0));

      for (int i = 0; i < c_nvec; i++)
         apply($sformatf("vec%0d", i), tbl[i]);

`ifdef IFU_ADDR_CHECK_EN
      apply("chk_rst",      mk(1, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0,          32'h0000_3000, 1, 32'd0, 0));
      apply("chk_last_ok",  mk(0, 0, 2'b11, 0, 16'h0, 26'h0, 32'h0000_6FFC, 32'h0000_6FFC, 1, 32'd1, 0));
      apply("chk_past_end", mk(0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0,          32'h0000_6FFC, 0, 32'd1, 1));
      apply("chk_halt_seq", mk(0, 0, 2'b11, 0, 16'h0, 26'h0, 32'h0000_3000, 32'h0000_6FFC, 0, 32'd1, 1));
      apply("chk_halt_stl", mk(0, 1, 2'b00, 0, 16'h0, 26'h0, 32'h0,          32'h0000_6FFC, 0, 32'd1, 1));
      apply("chk_rst2",     mk(1, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0,          32'h0000_3000, 1, 32'd0, 0));
      apply("chk_jr7000",   mk(0, 0, 2'b11, 0, 16'h0, 26'h0, 32'h0000_7000, 32'h0000_3000, 0, 32'd0, 1));
      apply("chk_rst3",     mk(1, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0,          32'h0000_3000, 1, 32'd0, 0));
      apply("chk_misalign", mk(0, 0, 2'b11, 0, 16'h0, 26'h0, 32'h0000_3002, 32'h0000_3000, 0, 32'd0, 1));
      apply("chk_rst4",     mk(1, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0,          32'h0000_3000, 1, 32'd0, 0));
      apply("chk_below",    mk(0, 0, 2'b11, 0, 16'h0, 26'h0, 32'h0000_2FFC, 32'h0000_3000, 0, 32'd0, 1));
`else
      apply("wrap_jr_top",  mk(0, 0, 2'b11, 0, 16'h0,    26'h0,         32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 32'd4, 0));
      apply("wrap_seq",     mk(0, 0, 2'b00, 0, 16'h0,    26'h0,         32'h0,          32'h0000_0000, 1, 32'd5, 0));
      apply("wrap_br_back", mk(0, 0, 2'b01, 1, 16'h8000, 26'h0,         32'h0,          32'hFFFE_0004, 1, 32'd6, 0));
      apply("jr_high",      mk(0, 0, 2'b11, 0, 16'h0,    26'h0,         32'hF000_0000, 32'hF000_0000, 1, 32'd7, 0));
      apply("j_keeps_top",  mk(0, 0, 2'b10, 0, 16'h0,    26'h0000010,   32'h0,          32'hF000_0040, 1, 32'd8, 0));
      apply("no_check",     mk(0, 0, 2'b11, 0, 16'h0,    26'h0,         32'h0000_7000, 32'h0000_7000, 1, 32'd9, 0));
      apply("no_check_mis", mk(0, 0, 2'b11, 0, 16'h0,    26'h0,         32'h0000_3002, 32'h0000_3002, 1, 32'd10, 0));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
